// File: rtl/sram_like_pkg.sv
// Shared types and constants for the SRAM-like bus responder and its helpers.
package sram_like_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Fibonacci LFSR, taps 16,14,13,11 map to bit positions 15,13,12,10
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic lfsr_fb(input logic [15:0] s);
        return ^(s & LFSR_TAPS);
    endfunction

endpackage

// File: rtl/sram_like_wstrb.sv
// Byte-lane write strobe from bus size and low address bits.
module sram_like_wstrb
    import sram_like_pkg::*;
(
    input  logic [1:0] i_size,
    input  logic [1:0] i_addr_lo,
    output logic [3:0] o_wstrb
);

    always_comb begin
        o_wstrb = '0;
        case (i_size)
            SIZE_BYTE: o_wstrb = 4'b0001 << i_addr_lo;
            SIZE_HALF: o_wstrb = i_addr_lo[1] ? 4'b1100 : 4'b0011;
            default:   o_wstrb = 4'b1111 << i_addr_lo;
        endcase
    end

endmodule

// File: rtl/sram_like_ram_slave.sv
// SRAM-like bus responder backed by a word RAM with programmable accept/data latency.
// Optional random accept stalls when SRAM_LIKE_STALL_LFSR_EN is defined.
module sram_like_ram_slave
    import sram_like_pkg::*;
#(
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned ADDR_LAT = 0,
    parameter int unsigned DATA_LAT = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata
);

    localparam logic [3:0] ACNT_INIT = 4'(ADDR_LAT);
    localparam logic [3:0] DCNT_INIT = 4'(DATA_LAT - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [3:0]         r_acnt;
    logic [3:0]         w_acnt_nxt;
    logic [3:0]         r_dcnt;
    logic [3:0]         w_dcnt_nxt;
    logic               w_accept;
    logic               w_stall_ok;
    logic [3:0]         w_wstrb;
    logic [ADDR_W-1:0]  w_idx;
    logic               w_unused;
    logic [31:0]        r_mem [0:(1<<ADDR_W)-1];

    assign w_idx    = addr[ADDR_W+1:2];
    assign w_unused = ^addr[31:ADDR_W+2];
    assign w_accept = req & addr_ok;

`ifdef SRAM_LIKE_STALL_LFSR_EN
    logic [15:0] r_lfsr;

    always_ff @(posedge clk) begin
        if (!resetn) r_lfsr <= LFSR_SEED;
        else         r_lfsr <= {r_lfsr[14:0], lfsr_fb(r_lfsr)};
    end

    assign w_stall_ok = r_lfsr[0];
`else
    assign w_stall_ok = 1'b1;
`endif

    sram_like_wstrb u_wstrb (
        .i_size    (size),
        .i_addr_lo (addr[1:0]),
        .o_wstrb   (w_wstrb)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= IDLE;
            r_acnt  <= ACNT_INIT;
            r_dcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_acnt  <= w_acnt_nxt;
            r_dcnt  <= w_dcnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_acnt_nxt  = r_acnt;
        w_dcnt_nxt  = r_dcnt;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = BUSY;
                    w_dcnt_nxt  = DCNT_INIT;
                end else if (r_acnt != '0) begin
                    w_acnt_nxt = r_acnt - 4'd1;
                end
            end
            BUSY: begin
                if (r_dcnt == '0) begin
                    w_state_nxt = IDLE;
                    w_acnt_nxt  = ACNT_INIT;
                end else begin
                    w_dcnt_nxt = r_dcnt - 4'd1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Gated by resetn so both handshakes read low for the whole reset window
    always_comb begin
        addr_ok = resetn && (r_state == IDLE) && (r_acnt == '0) && w_stall_ok;
        data_ok = resetn && (r_state == BUSY) && (r_dcnt == '0);
    end

    always_ff @(posedge clk) begin
        if (w_accept && wr) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (w_wstrb[b]) r_mem[w_idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn)             rdata <= '0;
        else if (w_accept && !wr) rdata <= r_mem[w_idx];
    end

endmodule

// File: tb/tb_sram_like_ram_slave.sv
// Directed + randomized bench for sram_like_ram_slave against a lane-level memory model.
module tb_sram_like_ram_slave;

    logic        clk;
    logic        rstn_v  [3];
    logic        req_v   [3];
    logic        wr_v    [3];
    logic [1:0]  size_v  [3];
    logic [31:0] addr_v  [3];
    logic [31:0] wdata_v [3];
    logic        aok_v   [3];
    logic        dok_v   [3];
    logic [31:0] rd_v    [3];

    int          n_assert;
    int          n_fail;
    bit [31:0]   mdl [int];
    bit [31:0]   last_rd [3];

    sram_like_ram_slave #(.ADDR_W(10), .ADDR_LAT(0), .DATA_LAT(1)) dut_a (
        .clk(clk), .resetn(rstn_v[0]), .req(req_v[0]), .wr(wr_v[0]), .size(size_v[0]),
        .addr(addr_v[0]), .wdata(wdata_v[0]), .addr_ok(aok_v[0]), .data_ok(dok_v[0]), .rdata(rd_v[0]));

    sram_like_ram_slave #(.ADDR_W(10), .ADDR_LAT(2), .DATA_LAT(3)) dut_b (
        .clk(clk), .resetn(rstn_v[1]), .req(req_v[1]), .wr(wr_v[1]), .size(size_v[1]),
        .addr(addr_v[1]), .wdata(wdata_v[1]), .addr_ok(aok_v[1]), .data_ok(dok_v[1]), .rdata(rd_v[1]));

    sram_like_ram_slave #(.ADDR_W(10), .ADDR_LAT(0), .DATA_LAT(4)) dut_c (
        .clk(clk), .resetn(rstn_v[2]), .req(req_v[2]), .wr(wr_v[2]), .size(size_v[2]),
        .addr(addr_v[2]), .wdata(wdata_v[2]), .addr_ok(aok_v[2]), .data_ok(dok_v[2]), .rdata(rd_v[2]));

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int mkey(input int s, input bit [31:0] a);
        return s * 65536 + int'((a >> 2) % 1024);
    endfunction

    function automatic bit lane_on(input bit [1:0] sz, input bit [1:0] a, input int b);
        case (sz)
            2'b00:   return b == int'(a);
            2'b01:   return (b / 2) == (int'(a) / 2);
            default: return b >= int'(a);
        endcase
    endfunction

    task automatic reset_all(input int cyc);
        @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            rstn_v[s] = 1'b0;
            req_v[s]  = 1'b0;
        end
        repeat (cyc) begin
            @(negedge clk);
            for (int s = 0; s < 3; s++) begin
                check("rst_addr_ok", aok_v[s], 0);
                check("rst_data_ok", dok_v[s], 0);
                check("rst_rdata", rd_v[s], 0);
            end
        end
        for (int s = 0; s < 3; s++) rstn_v[s] = 1'b1;
        #1;
        check("rel_addr_ok_a", aok_v[0], 1);
        check("rel_addr_ok_b", aok_v[1], 0);
        check("rel_addr_ok_c", aok_v[2], 1);
        for (int s = 0; s < 3; s++) last_rd[s] = '0;
    endtask

    // Starts in the low half of a clock; returns with the DUT idle and addr_ok high.
    task automatic txn(input int s, input bit w, input bit [1:0] sz, input bit [31:0] a,
                       input bit [31:0] wd, input int dlat, input int alat, input bit hold,
                       output bit [31:0] rd, output int acc_wait);
        int n;
        int k;
        int j;
        int kk;
        bit [31:0] m;
        req_v[s] = 1'b1; wr_v[s] = w; size_v[s] = sz; addr_v[s] = a; wdata_v[s] = wd;
        rd = rd_v[s];
        n = 0;
        while (aok_v[s] !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        acc_wait = n;
        if (n >= 300) begin
            check("accept_timeout", 0, 1);
            req_v[s] = 1'b0;
            return;
        end
        kk = mkey(s, a);
        if (w) begin
            m = mdl.exists(kk) ? mdl[kk] : 32'h0;
            for (int b = 0; b < 4; b++)
                if (lane_on(sz, a[1:0], b)) m[8*b +: 8] = wd[8*b +: 8];
            mdl[kk] = m;
        end
        @(negedge clk);
        req_v[s] = hold; wr_v[s] = 1'($urandom); size_v[s] = 2'($urandom);
        addr_v[s] = $urandom; wdata_v[s] = $urandom;
        k = 1;
        while (dok_v[s] !== 1'b1 && k < 40) begin
            check("busy_addr_ok", aok_v[s], 0);
            @(negedge clk);
            k++;
        end
        check("data_lat", k, dlat);
        check("addr_ok_in_dok", aok_v[s], 0);
        if (!w) begin
            last_rd[s] = mdl[kk];
            check("rdata", rd_v[s], mdl[kk]);
        end else begin
            check("rdata_hold_wr", rd_v[s], last_rd[s]);
        end
        rd = rd_v[s];
        @(negedge clk);
        check("dok_pulse", dok_v[s], 0);
        j = 1;
        while (aok_v[s] !== 1'b1 && j < 300) begin
            @(negedge clk);
            j++;
        end
`ifndef SRAM_LIKE_STALL_LFSR_EN
        check("reaccept_gap", j, alat + 1);
`else
        check("reaccept_bound", j < 300, 1);
`endif
        if (!hold) req_v[s] = 1'b0;
    endtask

    initial begin
        bit [31:0] rd;
        int        aw;
        int        n;
        bit        w;
        bit [1:0]  sz;
        bit [31:0] a;
        n_assert = 0;
        n_fail   = 0;
        clk      = 1'b0;
        for (int s = 0; s < 3; s++) begin
            rstn_v[s] = 1'b0; req_v[s] = 1'b0; wr_v[s] = 1'b0;
            size_v[s] = '0; addr_v[s] = '0; wdata_v[s] = '0;
        end

        reset_all(3);

        // word write / read on the fastest instance
        txn(0, 1'b1, 2'b10, 32'h10, 32'hDEADBEEF, 1, 0, 1'b0, rd, aw);
`ifndef SRAM_LIKE_STALL_LFSR_EN
        check("first_accept_wait", aw, 0);
`endif
        txn(0, 1'b0, 2'b10, 32'h10, 32'h0, 1, 0, 1'b0, rd, aw);
        check("word_read", rd, 32'hDEADBEEF);

        // byte lanes
        txn(0, 1'b1, 2'b10, 32'h20, 32'h11223344, 1, 0, 1'b0, rd, aw);
        txn(0, 1'b1, 2'b00, 32'h22, 32'h00AA0000, 1, 0, 1'b0, rd, aw);
        txn(0, 1'b1, 2'b01, 32'h20, 32'h0000BBCC, 1, 0, 1'b0, rd, aw);
        txn(0, 1'b0, 2'b00, 32'h20, 32'h0, 1, 0, 1'b0, rd, aw);
        check("lane_merge", rd, 32'h11AABBCC);

        // aliasing of upper address bits
        txn(0, 1'b1, 2'b10, 32'h00001004, 32'h5A5A5A5A, 1, 0, 1'b0, rd, aw);
        txn(0, 1'b0, 2'b10, 32'h00000004, 32'h0, 1, 0, 1'b0, rd, aw);
        check("alias_read", rd, 32'h5A5A5A5A);

        // latency instance, req held through BUSY and re-idle
        reset_all(2);
        txn(1, 1'b1, 2'b10, 32'h40, 32'h0BADCAFE, 3, 2, 1'b1, rd, aw);
`ifndef SRAM_LIKE_STALL_LFSR_EN
        check("lat_first_accept", aw, 2);
`endif
        txn(1, 1'b0, 2'b10, 32'h40, 32'h0, 3, 2, 1'b1, rd, aw);
        req_v[1] = 1'b0;
`ifndef SRAM_LIKE_STALL_LFSR_EN
        check("lat_back_to_back", aw, 0);
`endif
        check("lat_read", rd, 32'h0BADCAFE);

        // reset two cycles into a DATA_LAT=4 write
        n = 0;
        while (aok_v[2] !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("midrst_accept_bound", n < 300, 1);
        req_v[2] = 1'b1; wr_v[2] = 1'b1; size_v[2] = 2'b10;
        addr_v[2] = 32'h30; wdata_v[2] = 32'hCAFEF00D;
        mdl[mkey(2, 32'h30)] = 32'hCAFEF00D;
        @(negedge clk);
        req_v[2] = 1'b0;
        check("midrst_dok_k1", dok_v[2], 0);
        @(negedge clk);
        rstn_v[2] = 1'b0;
        #1;
        check("midrst_dok_k2", dok_v[2], 0);
        repeat (3) begin
            @(negedge clk);
            check("midrst_dok_in_rst", dok_v[2], 0);
            check("midrst_aok_in_rst", aok_v[2], 0);
        end
        rstn_v[2] = 1'b1;
        #1;
        check("midrst_rdata_cleared", rd_v[2], 0);
        last_rd[2] = '0;
        repeat (2) begin
            @(negedge clk);
            check("midrst_dok_after", dok_v[2], 0);
        end
        n = 0;
        while (aok_v[2] !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        txn(2, 1'b0, 2'b10, 32'h30, 32'h0, 4, 0, 1'b0, rd, aw);
        check("midrst_read", rd, 32'hCAFEF00D);

        // randomized traffic against the model on a small aliased window
        for (int i = 0; i < 8; i++)
            txn(0, 1'b1, 2'b10, 32'h100 + 32'(4 * i), $urandom, 1, 0, 1'b0, rd, aw);
        for (int i = 0; i < 60; i++) begin
            w  = 1'($urandom);
            sz = 2'($urandom);
            a  = (32'h100 + $urandom_range(0, 31)) | ($urandom & 32'hFFFFF000);
            txn(0, w, sz, a, $urandom, 1, 0, 1'b0, rd, aw);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
